// File: rtl/des_f_serial.sv
// -----------------------------------------------------------------------------
// des_f_serial -- sequential DES round function f(R, K)
//
// Computes P(S(E(R) ^ K)), evaluating one S-box per cycle so a single 6-bit
// chunk path and a single 4-bit collect path are shared by all eight boxes.
// Operands arrive and results leave through valid/ready handshakes.
//
// Bit numbering: port bit [n] of a W-bit vector is FIPS 46-3 bit W+1-n, so
// the MSB of every vector is FIPS bit 1.
//
// Modules in this file:
//   sbox1 .. sbox8  -- DES S-box lookups, Bin[6:1] -> BSout[4:1]
//   des_f_serial    -- top level
//
// des_f_serial ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   r_in / k_in valid
//   in_ready   out  1   block can accept an operand (IDLE only)
//   r_in       in  32   R half
//   k_in       in  48   round subkey
//   out_valid  out  1   f_out valid (DONE only)
//   out_ready  in   1   consumer accepts f_out
//   f_out      out 32   f(R, K)
// -----------------------------------------------------------------------------

// S-box lookups. Each ROM constant holds the 64 four-bit entries of one
// FIPS S-box in row-major order (row 0 column 0 in the top nibble). The row
// is formed from the outer bits b1/b6, the column from b2..b5. Address a
// lives at bit offset 4*(63-a), which is simply {~a, 2'b00}.

module sbox1 (
  input  logic [6:1] Bin,
  output logic [4:1] BSout
);
  localparam logic [255:0] SBOX_ROM =
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  assign BSout = SBOX_ROM[{~{Bin[6], Bin[1], Bin[5:2]}, 2'b00} +: 4];
endmodule

module sbox2 (
  input  logic [6:1] Bin,
  output logic [4:1] BSout
);
  localparam logic [255:0] SBOX_ROM =
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  assign BSout = SBOX_ROM[{~{Bin[6], Bin[1], Bin[5:2]}, 2'b00} +: 4];
endmodule

module sbox3 (
  input  logic [6:1] Bin,
  output logic [4:1] BSout
);
  localparam logic [255:0] SBOX_ROM =
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  assign BSout = SBOX_ROM[{~{Bin[6], Bin[1], Bin[5:2]}, 2'b00} +: 4];
endmodule

module sbox4 (
  input  logic [6:1] Bin,
  output logic [4:1] BSout
);
  localparam logic [255:0] SBOX_ROM =
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  assign BSout = SBOX_ROM[{~{Bin[6], Bin[1], Bin[5:2]}, 2'b00} +: 4];
endmodule

module sbox5 (
  input  logic [6:1] Bin,
  output logic [4:1] BSout
);
  localparam logic [255:0] SBOX_ROM =
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  assign BSout = SBOX_ROM[{~{Bin[6], Bin[1], Bin[5:2]}, 2'b00} +: 4];
endmodule

module sbox6 (
  input  logic [6:1] Bin,
  output logic [4:1] BSout
);
  localparam logic [255:0] SBOX_ROM =
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  assign BSout = SBOX_ROM[{~{Bin[6], Bin[1], Bin[5:2]}, 2'b00} +: 4];
endmodule

module sbox7 (
  input  logic [6:1] Bin,
  output logic [4:1] BSout
);
  localparam logic [255:0] SBOX_ROM =
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  assign BSout = SBOX_ROM[{~{Bin[6], Bin[1], Bin[5:2]}, 2'b00} +: 4];
endmodule

module sbox8 (
  input  logic [6:1] Bin,
  output logic [4:1] BSout
);
  localparam logic [255:0] SBOX_ROM =
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
  assign BSout = SBOX_ROM[{~{Bin[6], Bin[1], Bin[5:2]}, 2'b00} +: 4];
endmodule

module des_f_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:1] r_in,
  input  logic [48:1] k_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:1] f_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Expansion E, written out as a concatenation in FIPS output order.
  // FIPS input bit b is port bit r[33-b].
  function automatic logic [48:1] e_expand(input logic [32:1] r);
    return {r[1],  r[32], r[31], r[30], r[29], r[28],
            r[29], r[28], r[27], r[26], r[25], r[24],
            r[25], r[24], r[23], r[22], r[21], r[20],
            r[21], r[20], r[19], r[18], r[17], r[16],
            r[17], r[16], r[15], r[14], r[13], r[12],
            r[13], r[12], r[11], r[10], r[9],  r[8],
            r[9],  r[8],  r[7],  r[6],  r[5],  r[4],
            r[5],  r[4],  r[3],  r[2],  r[1],  r[32]};
  endfunction

  // Permutation P in FIPS output order; FIPS input bit b is s[33-b].
  function automatic logic [32:1] p_permute(input logic [32:1] s);
    return {s[17], s[26], s[13], s[12], s[4],  s[21], s[5],  s[16],
            s[32], s[18], s[10], s[7],  s[28], s[15], s[2],  s[23],
            s[31], s[25], s[9],  s[19], s[1],  s[6],  s[30], s[24],
            s[14], s[20], s[3],  s[27], s[11], s[22], s[29], s[8]};
  endfunction

  state_t      r_state;
  logic [48:1] r_x;          // E(R)^K, shifted left one chunk per RUN cycle
  logic [32:1] r_s;          // S-box results, collected MSB-nibble first
  logic [2:0]  r_idx;        // S-box being evaluated this cycle (0 = S1)
  logic        r_in_ready;
  logic        r_out_valid;

  logic [6:1]  w_chunk;
  logic [4:1]  w_bs [8];
  logic [4:1]  w_bs_sel;

  // The next chunk always sits at the top of r_x; every box sees it, and
  // r_idx picks which box's answer is meaningful this cycle.
  assign w_chunk = r_x[48:43];

  sbox1 u_sbox1 (.Bin(w_chunk), .BSout(w_bs[0]));
  sbox2 u_sbox2 (.Bin(w_chunk), .BSout(w_bs[1]));
  sbox3 u_sbox3 (.Bin(w_chunk), .BSout(w_bs[2]));
  sbox4 u_sbox4 (.Bin(w_chunk), .BSout(w_bs[3]));
  sbox5 u_sbox5 (.Bin(w_chunk), .BSout(w_bs[4]));
  sbox6 u_sbox6 (.Bin(w_chunk), .BSout(w_bs[5]));
  sbox7 u_sbox7 (.Bin(w_chunk), .BSout(w_bs[6]));
  sbox8 u_sbox8 (.Bin(w_chunk), .BSout(w_bs[7]));

  // 8:1 result mux.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // w_bs_sel unassigned, which would infer a latch.
    w_bs_sel = 4'h0;
    case (r_idx)
      3'd0:    w_bs_sel = w_bs[0];
      3'd1:    w_bs_sel = w_bs[1];
      3'd2:    w_bs_sel = w_bs[2];
      3'd3:    w_bs_sel = w_bs[3];
      3'd4:    w_bs_sel = w_bs[4];
      3'd5:    w_bs_sel = w_bs[5];
      3'd6:    w_bs_sel = w_bs[6];
      default: w_bs_sel = w_bs[7];
    endcase
  end

  // Control and datapath in one process; handshake outputs are registered
  // so neither in_ready nor out_valid depends combinationally on any input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: r_x and r_s are plain flops, not a RAM, so they take a reset;
      // clearing r_s is what makes f_out read P(0) = 0 out of reset.
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_s         <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // below reads the value from before this edge (r_x shifts while the
      // S-box sees the old top chunk).
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x        <= e_expand(r_in) ^ k_in;
            r_s        <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_s   <= {r_s[28:1], w_bs_sel};
          r_x   <= {r_x[42:1], 6'b0};
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          // r_s holds until the consumer takes the result. No new operand
          // is accepted in the handoff cycle; IDLE follows first.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign f_out     = p_permute(r_s);

endmodule

// File: tb/tb_des_f_serial.sv
// -----------------------------------------------------------------------------
// tb_des_f_serial -- directed and random checks for des_f_serial.
// Expected values are hand-derived constants or come from a table-driven
// reference f() written in FIPS numbering.
// -----------------------------------------------------------------------------
module tb_des_f_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] r_in = '0;
  logic [47:0] k_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] f_out;

  int n_vec  = 0;
  int n_miss = 0;

  int cyc      = 0;
  int last_acc = -1;
  int prev_acc = -1;

  des_f_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .k_in      (k_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out)
  );

  always #5 clk = ~clk;

  // Records the cycle numbers of the two most recent operand accepts.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      prev_acc <= last_acc;
      last_acc <= cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want finish before it");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model, FIPS 46-3 tables (FIPS bit b of a W-bit vector is [W-b])
  // ---------------------------------------------------------------------------
  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int SBOX_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [47:0] ref_e(input logic [31:0] r);
    logic [47:0] e;
    for (int i = 1; i <= 48; i++) e[48-i] = r[32-E_TAB[i-1]];
    return e;
  endfunction

  function automatic logic [31:0] ref_s(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  c;
    int          row, col;
    for (int j = 0; j < 8; j++) begin
      c   = x[47-6*j -: 6];
      row = {c[5], c[0]};
      col = c[4:1];
      s[31-4*j -: 4] = 4'(SBOX_T[j][row*16 + col]);
    end
    return s;
  endfunction

  function automatic logic [31:0] ref_p(input logic [31:0] s);
    logic [31:0] p;
    for (int i = 1; i <= 32; i++) p[32-i] = s[32-P_TAB[i-1]];
    return p;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    return ref_p(ref_s(ref_e(r) ^ k));
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside; callers check what they return)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operand until it is accepted; ok = 0 if never accepted.
  task automatic send(input logic [31:0] r, input logic [47:0] k, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    r_in     = r;
    k_in     = k;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (f_out !== 32'h0) begin n_miss++; $display("FAIL reset_f_out: got %h want 00000000", f_out); end
    n_vec++; if (dut.r_x !== 48'h0) begin n_miss++; $display("FAIL reset_x: got %h want 0", dut.r_x); end
    n_vec++; if (dut.r_s !== 32'h0) begin n_miss++; $display("FAIL reset_s: got %h want 0", dut.r_s); end
    n_vec++; if (dut.r_idx !== 3'd0) begin n_miss++; $display("FAIL reset_idx: got %0d want 0", dut.r_idx); end
    rst = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fips_vector();
    bit ok;
    int lat;
    send(32'hF0AAF0AA, 48'h1B02EFFC7072, ok);
    n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL fips_accept: got %b want 1", ok); end
    n_vec++; if (dut.r_x !== 48'h6117BA866527) begin n_miss++; $display("FAIL fips_x_load: got %h want 6117ba866527", dut.r_x); end
    wait_out(lat);
    n_vec++; if (lat !== 8) begin n_miss++; $display("FAIL fips_latency: got %0d want 8", lat); end
    n_vec++; if (dut.r_s !== 32'h5C82B597) begin n_miss++; $display("FAIL fips_s: got %h want 5c82b597", dut.r_s); end
    n_vec++; if (f_out !== 32'h234AA9BB) begin n_miss++; $display("FAIL fips_f_out: got %h want 234aa9bb", f_out); end
    handoff();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL fips_valid_drop: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL fips_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_vector();
    bit ok;
    int lat;
    send(32'h0, 48'h0, ok);
    n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL zero_accept: got %b want 1", ok); end
    wait_out(lat);
    n_vec++; if (lat !== 8) begin n_miss++; $display("FAIL zero_latency: got %0d want 8", lat); end
    n_vec++; if (dut.r_s !== 32'hEFA72C4D) begin n_miss++; $display("FAIL zero_s: got %h want efa72c4d", dut.r_s); end
    n_vec++; if (f_out !== 32'hD8D8DBBC) begin n_miss++; $display("FAIL zero_f_out: got %h want d8d8dbbc", f_out); end
    handoff();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL zero_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    send(32'hF0AAF0AA, 48'h1B02EFFC7072, ok);
    n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL bp_accept: got %b want 1", ok); end
    wait_out(lat);
    n_vec++; if (lat !== 8) begin n_miss++; $display("FAIL bp_latency: got %0d want 8", lat); end
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, out_valid); end
      n_vec++; if (f_out !== 32'h234AA9BB) begin n_miss++; $display("FAIL bp_f_hold[%0d]: got %h want 234aa9bb", i, f_out); end
      n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      if (i < 5) tick();
    end
    handoff();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
  endtask

  // in_valid stays high from the first accept to the second; out_ready is
  // high the whole time, including before DONE.
  task automatic test_back_to_back();
    int lat;
    in_valid  = 1'b1;
    r_in      = 32'hF0AAF0AA;
    k_in      = 48'h1B02EFFC7072;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_busy_ready[%0d]: got %b want 0", i, in_ready); end
      r_in = $urandom;
      k_in = {16'($urandom), $urandom};
      tick();
    end
    n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_valid1: got %b want 1", out_valid); end
    n_vec++; if (f_out !== 32'h234AA9BB) begin n_miss++; $display("FAIL b2b_f1: got %h want 234aa9bb", f_out); end
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_done_ready: got %b want 0", in_ready); end
    r_in = 32'h0;
    k_in = 48'h0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_valid_drop: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_idle_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    n_vec++; if (lat !== 8) begin n_miss++; $display("FAIL b2b_latency2: got %0d want 8", lat); end
    n_vec++; if (f_out !== 32'hD8D8DBBC) begin n_miss++; $display("FAIL b2b_f2: got %h want d8d8dbbc", f_out); end
    n_vec++; if (last_acc - prev_acc !== 10) begin n_miss++; $display("FAIL b2b_interval: got %0d want 10", last_acc - prev_acc); end
    tick();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_valid_drop2: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int lat;
    send(32'hF0AAF0AA, 48'h1B02EFFC7072, ok);
    n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL rmr_accept: got %b want 1", ok); end
    repeat (4) tick();
    n_vec++; if (dut.r_idx !== 3'd4) begin n_miss++; $display("FAIL rmr_idx: got %0d want 4", dut.r_idx); end
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rmr_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL rmr_ready: got %b want 1", in_ready); end
    n_vec++; if (f_out !== 32'h0) begin n_miss++; $display("FAIL rmr_f_clear: got %h want 00000000", f_out); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rmr_stale[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
    send(32'h0, 48'h0, ok);
    n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL rmr_accept2: got %b want 1", ok); end
    wait_out(lat);
    n_vec++; if (lat !== 8) begin n_miss++; $display("FAIL rmr_latency: got %0d want 8", lat); end
    n_vec++; if (f_out !== 32'hD8D8DBBC) begin n_miss++; $display("FAIL rmr_f_out: got %h want d8d8dbbc", f_out); end
    handoff();
  endtask

  task automatic test_random_sweep();
    bit          ok;
    int          lat;
    logic [31:0] r;
    logic [47:0] k;
    logic [31:0] want;
    int          stall;
    for (int n = 0; n < 1000; n++) begin
      r    = $urandom;
      k    = {16'($urandom), $urandom};
      want = ref_f(r, k);
      send(r, k, ok);
      n_vec++;
      if (ok !== 1'b1) begin
        n_miss++;
        $display("FAIL rnd_accept[%0d]: got %b want 1", n, ok);
        break;
      end
      wait_out(lat);
      n_vec++; if (lat !== 8) begin n_miss++; $display("FAIL rnd_latency[%0d]: got %0d want 8", n, lat); end
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      n_vec++;
      if (f_out !== want) begin
        n_miss++;
        $display("FAIL rnd_f_out[%0d]: r=%h k=%h got %h want %h", n, r, k, f_out, want);
      end
      handoff();
    end
  endtask

  initial begin
    test_reset();
    test_fips_vector();
    test_zero_vector();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
